// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Digit word layout: {enable, hex[3:0]}.
package seg7_scan_ctrl_pkg;

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam int DW       = 5;
  localparam int DW_EN    = 4;
  localparam int DW_HEX_H = 3;
  localparam int DW_HEX_L = 0;

  // Segment order {g,f,e,d,c,b,a}; entry 15 first
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_scan_ctrl_hex2seg.sv
// Combinational hex digit to 7-segment pattern decoder.
// Active-high segments, {g,f,e,d,c,b,a}.
module hex2seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TBL[i_hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with blanking gap and
// frame-aligned atomic commit of a shadow digit bank.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NDIGITS = 2,
  parameter int REFRESH = 2,
  parameter int BLANK   = 1,
  parameter int AW      = (NDIGITS > 2) ? $clog2(NDIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic               commit,
  output logic               commit_pending,
  output logic               commit_ack,
  output logic [6:0]         led_port,
  output logic [NDIGITS-1:0] dig_en
);

  localparam int MX = (REFRESH > BLANK) ? REFRESH : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [AW-1:0] LAST = AW'(NDIGITS - 1);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [AW-1:0]        r_idx;
  logic [DW-1:0]        r_shadow [NDIGITS];
  logic [DW-1:0]        r_disp   [NDIGITS];
  logic                 r_pending;
  logic                 r_ack;
  logic [6:0]           r_led;
  logic [NDIGITS-1:0]   r_dig;

  logic                 w_show_done;
  logic                 w_gap_done;
  logic                 w_adv;
  logic                 w_to_gap;
  logic                 w_start;
  logic                 w_copy;
  logic                 w_wr_ok;
  logic [AW-1:0]        w_nidx;
  logic [DW-1:0]        w_word;
  logic [6:0]           w_seg;

  assign w_show_done = int'(r_cnt) >= REFRESH - 1;
  assign w_gap_done  = int'(r_cnt) + 1 >= BLANK;

  assign w_adv = (r_state == ST_GAP) ? w_gap_done
               : (w_show_done && BLANK == 0);
  assign w_to_gap = (r_state == ST_SHOW) && w_show_done
                 && (BLANK != 0);

  assign w_nidx  = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  assign w_start = w_adv && (w_nidx == '0);
  assign w_copy  = w_start && r_pending;
  assign w_wr_ok = wr_en && (int'(wr_addr) < NDIGITS);

  // Frame-start copy must be visible in the digit-0 slot it opens
  assign w_word = w_copy ? r_shadow[0] : r_disp[w_nidx];

  hex2seg u_dec (
    .i_hex (w_word[DW_HEX_H:DW_HEX_L]),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIGITS; i++)
        r_shadow[i] <= '0;
    end else if (w_wr_ok) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_GAP;
      r_cnt     <= '1;
      r_idx     <= LAST;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_led     <= '0;
      r_dig     <= '0;
      for (int i = 0; i < NDIGITS; i++)
        r_disp[i] <= '0;
    end else begin
      r_ack     <= w_copy;
      r_pending <= w_copy ? 1'b0 : (r_pending | commit);
      if (w_copy) begin
        for (int i = 0; i < NDIGITS; i++)
          r_disp[i] <= r_shadow[i];
      end
      if (w_adv) begin
        r_state <= ST_SHOW;
        r_idx   <= w_nidx;
        r_cnt   <= '0;
        r_dig   <= NDIGITS'(1) << w_nidx;
        r_led   <= w_word[DW_EN] ? w_seg : 7'h00;
      end else if (w_to_gap) begin
        r_state <= ST_GAP;
        r_cnt   <= '0;
        r_dig   <= '0;
        r_led   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign commit_pending = r_pending;
  assign commit_ack     = r_ack;
  assign led_port       = r_led;
  assign dig_en         = r_dig;

endmodule
